// File: rtl/blake_job_arbiter.sv
// blake_job_arbiter: round-robin arbiter sharing one blake core among NREQ requesters,
// with a per-job completion timeout.
module blake_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255,
  parameter int IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*640-1:0]  req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [511:0]         rsp_data,
  input  logic                 rsp_ready,
  output logic [639:0]         core_din,
  output logic                 core_ena,
  input  logic                 core_rdy,
  input  logic [511:0]         core_dout,
  output logic                 busy,
  output logic                 err_timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;
  state_t state, state_nxt;
  logic [IDW-1:0] rr_ptr, job_id, grant, idx;
  logic [IDW:0] sum;
  logic [CW-1:0] tcnt;
  logic any_req, accept, done, tout, hshk;
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
  endfunction
  // Walk downward so the closest valid requester at or after rr_ptr wins.
  always_comb begin
    grant = '0;
    any_req = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      sum = (sum >= (IDW+1)'(NREQ)) ? sum - (IDW+1)'(NREQ) : sum;
      idx = sum[IDW-1:0];
      if (req_valid[idx]) begin
        grant = idx;
        any_req = 1'b1;
      end
    end
  end
  assign accept = (state == IDLE) && any_req;
  assign done   = (state == BUSY) && core_rdy;
  assign tout   = (state == BUSY) && !core_rdy && (tcnt == CW'(TIMEOUT));
  assign hshk   = (state == RESP) && rsp_ready;
  always_ff @(posedge clk)
    state <= !rstb ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = any_req ? ISSUE : IDLE;
      ISSUE:   state_nxt = BUSY;
      BUSY:    state_nxt = done ? RESP : (tout ? IDLE : BUSY);
      default: state_nxt = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_comb begin
    req_ready = accept ? NREQ'(1) << grant : '0;
    core_ena  = (state == ISSUE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rstb) begin
      rr_ptr      <= '0;
      job_id      <= '0;
      core_din    <= '0;
      tcnt        <= '0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (accept) begin
        core_din <= req_data[640*grant +: 640];
        job_id   <= grant;
      end
      tcnt <= (state == ISSUE) ? '0 : (state == BUSY) ? tcnt + 1'b1 : tcnt;
      if (done) begin
        rsp_data <= core_dout;
        rsp_id   <= job_id;
      end
      err_timeout <= tout;
      rr_ptr <= tout ? next_id(job_id) : hshk ? next_id(rsp_id) : rr_ptr;
    end
  end
endmodule

// File: tb/tb_blake_job_arbiter.sv
// tb_blake_job_arbiter: directed scenario tests for blake_job_arbiter with
// hand-computed expectations.
module tb_blake_job_arbiter;
  localparam int NREQ = 4;
  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*640-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [511:0]      rsp_data;
  logic              rsp_ready = 1'b0;
  logic [639:0]      core_din;
  logic              core_ena;
  logic              core_rdy = 1'b0;
  logic [511:0]      core_dout = '0;
  logic              busy;
  logic              err_timeout;
  int checks = 0;
  int errors = 0;

  blake_job_arbiter #(.NREQ(NREQ), .TIMEOUT(255), .IDW(2)) dut (
    .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .core_din(core_din),
    .core_ena(core_ena), .core_rdy(core_rdy), .core_dout(core_dout),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [639:0] slot(input int i);
    return {20{32'hC0DE_0000 | 32'(i)}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstb = 1'b0;
    tick;
    tick;
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0 ||
        core_din !== '0 || core_ena !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rr=%b rv=%b id=%0d ena=%b busy=%b err=%b expected all zero",
               req_ready, rsp_valid, rsp_id, core_ena, busy, err_timeout);
    end
    rstb = 1'b1;
    tick;
  endtask

  task automatic test_single;
    logic [511:0] a5 = {64{8'hA5}};
    bit ok = 1'b1;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: req_ready=%b expected 0100", req_ready);
    end
    tick;
    req_valid = '0;
    #1;
    checks++;
    if (req_ready !== '0 || core_ena !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_issue: req_ready=%b core_ena=%b busy=%b expected 0000 1 1",
               req_ready, core_ena, busy);
    end
    checks++;
    if (core_din !== slot(2)) begin
      errors++;
      $display("FAIL single_core_din: got %h expected %h", core_din, slot(2));
    end
    tick;
    for (int i = 0; i < 129; i++) begin
      if (core_ena !== 1'b0 || rsp_valid !== 1'b0 || err_timeout !== 1'b0 || core_din !== slot(2))
        ok = 1'b0;
      tick;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_busy_wait: core_ena/rsp_valid/err_timeout/core_din not quiet while busy");
    end
    core_rdy = 1'b1;
    core_dout = a5;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp_early: rsp_valid=%b expected 0 in core_rdy cycle", rsp_valid);
    end
    tick;
    core_rdy = 1'b0;
    core_dout = '0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== a5) begin
      errors++;
      $display("FAIL single_rsp: rsp_valid=%b rsp_id=%0d rsp_data=%h expected 1 2 a5..a5",
               rsp_valid, rsp_id, rsp_data);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_handshake: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin;
    int g;
    rstb = 1'b0;
    tick;
    rstb = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      g = n % 4;
      checks++;
      if (req_ready !== 4'(1 << g)) begin
        errors++;
        $display("FAIL rr_grant_%0d: req_ready=%b expected %b", n, req_ready, 4'(1 << g));
      end
      tick;
      checks++;
      if (core_ena !== 1'b1 || core_din !== slot(g)) begin
        errors++;
        $display("FAIL rr_issue_%0d: core_ena=%b core_din=%h expected 1 %h", n, core_ena, core_din, slot(g));
      end
      tick;
      core_rdy = 1'b1;
      core_dout = {16{32'(n)}};
      tick;
      core_rdy = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_data !== {16{32'(n)}}) begin
        errors++;
        $display("FAIL rr_rsp_%0d: rsp_valid=%b rsp_id=%0d expected 1 %0d", n, rsp_valid, rsp_id, g);
      end
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
    end
    req_valid = '0;
    tick;
  endtask

  task automatic test_backpressure;
    logic [511:0] pat = {16{32'h1234_5678}};
    bit ok = 1'b1;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_grant: req_ready=%b expected 0010", req_ready);
    end
    tick;
    req_valid = '0;
    tick;
    core_rdy = 1'b1;
    core_dout = pat;
    tick;
    core_rdy = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      core_rdy = (i == 5);
      core_dout = {16{32'hDEAD_BEEF}};
      #1;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== pat || req_ready !== '0 || core_ena !== 1'b0)
        ok = 1'b0;
      tick;
    end
    core_rdy = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_hold: rsp_* not stable or req_ready/core_ena active; rsp_id=%0d rsp_data=%h", rsp_id, rsp_data);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    tick;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_timeout;
    bit ok = 1'b1;
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL to_grant: req_ready=%b expected 1000", req_ready);
    end
    tick;
    req_valid = '0;
    tick;
    for (int i = 0; i < 255; i++) begin
      if (busy !== 1'b1 || err_timeout !== 1'b0 || rsp_valid !== 1'b0)
        ok = 1'b0;
      tick;
    end
    checks++;
    if (!ok || busy !== 1'b1 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_wait: early exit or early err_timeout; busy=%b err_timeout=%b", busy, err_timeout);
    end
    tick;
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse: err_timeout=%b busy=%b rsp_valid=%b expected 1 0 0", err_timeout, busy, rsp_valid);
    end
    tick;
    checks++;
    if (err_timeout !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse_width: err_timeout=%b rsp_valid=%b expected 0 0", err_timeout, rsp_valid);
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL to_next_grant: req_ready=%b expected 0001", req_ready);
    end
    req_valid = '0;
    tick;
  endtask

  task automatic test_boundary;
    logic [511:0] pat = {16{32'h0BAD_F00D}};
    req_valid = 4'b0001;
    tick;
    req_valid = '0;
    tick;
    for (int i = 0; i < 255; i++) tick;
    core_rdy = 1'b1;
    core_dout = pat;
    tick;
    core_rdy = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== pat || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL boundary_rsp: rsp_valid=%b rsp_id=%0d err_timeout=%b expected 1 0 0",
               rsp_valid, rsp_id, err_timeout);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    checks++;
    if (err_timeout !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL boundary_noerr: err_timeout=%b rsp_valid=%b expected 0 0", err_timeout, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_busy;
    bit ok = 1'b1;
    req_valid = 4'b0010;
    tick;
    req_valid = '0;
    tick;
    for (int i = 0; i < 10; i++) tick;
    rstb = 1'b0;
    tick;
    rstb = 1'b1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0 ||
        core_din !== '0 || core_ena !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%b core_din=%h rsp_data=%h expected zeros", busy, core_din, rsp_data);
    end
    core_rdy = 1'b1;
    core_dout = {16{32'hFFFF_0000}};
    tick;
    core_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0 || rsp_data !== '0)
        ok = 1'b0;
      tick;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midreset_stray: rsp_valid=%b busy=%b err_timeout=%b expected 0 0 0", rsp_valid, busy, err_timeout);
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_ptr: req_ready=%b expected 0001", req_ready);
    end
    req_valid = '0;
    tick;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) req_data[640*i +: 640] = slot(i);
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_timeout;
    test_boundary;
    test_reset_mid_busy;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
